// File: rtl/uart_hex_tx.sv
// Sends i_byte as two ASCII hex characters (high nibble first) over an 8N1 UART line; UART_HEX_CRLF_EN appends CR LF.
// Start bit begins the cycle after accept; i_dv is ignored while o_ready is low (no queuing).
module uart_hex_tx #(
   parameter int CLKS_PER_BIT = 87
) (
   input  logic       clk,
   input  logic       i_rst_n,
   input  logic       i_dv,
   input  logic [7:0] i_byte,
   output logic       o_ready,
   output logic       o_tx_serial,
   output logic       o_tx_active,
   output logic       o_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
`ifdef UART_HEX_CRLF_EN
   localparam int IW = 2;
`else
   localparam int IW = 1;
`endif
   localparam logic [IW-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      NEXT
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [7:0]      byte_q, byte_d;

   logic [7:0]      char_w;
   logic            accept;
   logic            last_char;
   logic            bit_end;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   always_comb begin
      char_w = hex_ascii(byte_q[7:4]);
`ifdef UART_HEX_CRLF_EN
      case (idx_q)
         2'd0:    char_w = hex_ascii(byte_q[7:4]);
         2'd1:    char_w = hex_ascii(byte_q[3:0]);
         2'd2:    char_w = 8'h0D;
         default: char_w = 8'h0A;
      endcase
`else
      if (idx_q[0]) begin
         char_w = hex_ascii(byte_q[3:0]);
      end
`endif
   end

   assign last_char   = (idx_q == LAST_IDX);
   assign bit_end     = (cnt_q == CNT_MAX);
   assign o_done      = (state_q == NEXT) && last_char;
   // Ready in the final NEXT cycle lets a new message start with only the 1-cycle gap.
   assign o_ready     = (state_q == IDLE) || o_done;
   assign accept      = i_dv && o_ready;
   assign o_tx_active = (state_q != IDLE);

   always_comb begin
      case (state_q)
         START:   o_tx_serial = 1'b0;
         DATA:    o_tx_serial = char_w[bit_q];
         default: o_tx_serial = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      byte_d  = byte_q;
      if (accept) begin
         byte_d  = i_byte;
         idx_d   = '0;
         cnt_d   = '0;
         bit_d   = '0;
         state_d = START;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            START: begin
               if (bit_end) begin
                  cnt_d   = '0;
                  state_d = DATA;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  cnt_d = '0;
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_d = STOP;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  cnt_d   = '0;
                  state_d = NEXT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            NEXT: begin
               if (last_char) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = START;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         byte_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         byte_q  <= byte_d;
      end
   end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: directed and random bytes against a line-level model of the hex/8N1 message.
`timescale 1ns/1ps
module tb_uart_hex_tx;

   localparam int CPB = 87;
`ifdef UART_HEX_CRLF_EN
   localparam int NCH = 4;
`else
   localparam int NCH = 2;
`endif
   localparam int CHAR_CYC = 10 * CPB + 1;
   localparam int EXP_CYC  = NCH * CHAR_CYC - 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dv;
   logic [7:0] byt;
   logic       ready, tx, active, done;

   always #50 clk = ~clk;

   uart_hex_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .i_rst_n     (rst_n),
      .i_dv        (dv),
      .i_byte      (byt),
      .o_ready     (ready),
      .o_tx_serial (tx),
      .o_tx_active (active),
      .o_done      (done)
   );

   int compared   = 0;
   int mismatched = 0;
   int frame_err  = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] hex_char(input int nib);
      return (nib < 10) ? 8'(48 + nib) : 8'(65 + nib - 10);
   endfunction

   task automatic model_msg(input logic [7:0] b);
      exp_q.delete();
      exp_q.push_back(hex_char(int'(b) / 16));
      exp_q.push_back(hex_char(int'(b) % 16));
`ifdef UART_HEX_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
   endtask

   // Expected line level n cycles after acceptance.
   function automatic logic exp_line(input int n);
      int ch, pos;
      logic [7:0] c;
      ch  = n / CHAR_CYC;
      pos = n % CHAR_CYC;
      if (ch >= exp_q.size()) return 1'b1;
      c = exp_q[ch];
      if (pos < CPB) return 1'b0;
      if (pos < 9 * CPB) return c[(pos - CPB) / CPB];
      return 1'b1;
   endfunction

   // Independent UART receiver sampling mid-bit; a frame cut by reset is dropped.
   initial begin : mon
      logic [7:0] d;
      bit ok;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            ok = 1;
            d  = 8'h00;
            for (int k = 1; k <= CPB / 2 + 9 * CPB; k++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  ok = 0;
                  break;
               end
               if (k >= CPB / 2 && (k - CPB / 2) % CPB == 0) begin
                  int idx;
                  idx = (k - CPB / 2) / CPB;
                  if (idx == 0 && tx !== 1'b0) frame_err++;
                  else if (idx >= 1 && idx <= 8) d[idx-1] = tx;
                  else if (idx == 9 && tx !== 1'b1) frame_err++;
               end
            end
            if (ok) rx_q.push_back(d);
         end
      end
   end

   initial begin : watchdog
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic start_msg(input logic [7:0] b, input string tag);
      int w;
      w = 0;
      while (ready !== 1'b1 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_ready_wait"}, 32'(w < 4000), 1);
      model_msg(b);
      rx_q.delete();
      dv  = 1'b1;
      byt = b;
      @(negedge clk);
      dv  = 1'b0;
      byt = 8'($urandom);
      check({tag, "_start_lat"}, tx, 0);
      check({tag, "_ready_lo"}, ready, 0);
      check({tag, "_active_hi"}, active, 1);
   endtask

   // Called at the first negedge after acceptance; returns at the o_done negedge.
   task automatic finish_msg(input string tag, input int overlap_at);
      int n, rbad, lbad;
      n = 0; rbad = 0; lbad = 0;
      while (done !== 1'b1 && n < EXP_CYC + 200) begin
         if (tx !== exp_line(n)) lbad++;
         @(negedge clk);
         n++;
         if (n == overlap_at) begin
            dv  = 1'b1;
            byt = 8'h55;
         end else if (n == overlap_at + 1) begin
            dv = 1'b0;
         end
         if (done !== 1'b1 && ready !== 1'b0) rbad++;
      end
      check({tag, "_cycles"}, n, EXP_CYC);
      check({tag, "_line_bits"}, lbad, 0);
      check({tag, "_ready_busy"}, rbad, 0);
      check({tag, "_done_line"}, tx, 1);
      check({tag, "_done_ready"}, ready, 1);
      check({tag, "_done_active"}, active, 1);
      check({tag, "_nchar"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s_char%0d", tag, i),
               (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp_q[i]));
      check({tag, "_framing"}, frame_err, 0);
   endtask

   task automatic idle_after(input string tag);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_idle_active"}, active, 0);
      check({tag, "_idle_ready"}, ready, 1);
      check({tag, "_idle_line"}, tx, 1);
   endtask

   initial begin : main
      logic [7:0] dir [3];
      logic [7:0] b;
      int dcnt;
      dir = '{8'h3F, 8'h00, 8'h9F};
      rst_n = 1'b0;
      dv    = 1'b0;
      byt   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_line", tx, 1);
      check("rst_ready", ready, 1);
      check("rst_active", active, 0);
      check("rst_done", done, 0);

      // First rising edge after reset release must accept.
      rst_n = 1'b1;
      start_msg(8'hAB, "ab");
      finish_msg("ab", -5);
      idle_after("ab");

      foreach (dir[i]) begin
         start_msg(dir[i], $sformatf("dir%0d", i));
         finish_msg($sformatf("dir%0d", i), -5);
         idle_after($sformatf("dir%0d", i));
      end

      start_msg(8'hAB, "ovl");
      finish_msg("ovl", 100);
      idle_after("ovl");
      repeat (10) @(negedge clk);
      check("ovl_no_queue", active, 0);

      start_msg(8'hAB, "b2b_first");
      finish_msg("b2b_first", -5);
      dv  = 1'b1;
      byt = 8'h12;
      model_msg(8'h12);
      rx_q.delete();
      @(negedge clk);
      check("b2b_start_bit", tx, 0);
      check("b2b_active", active, 1);
      check("b2b_ready", ready, 0);
      check("b2b_done_clear", done, 0);
      dv = 1'b0;
      finish_msg("b2b", -5);
      idle_after("b2b");

      start_msg(8'hAB, "rst");
      repeat (500) @(negedge clk);
      check("rst_pre_line", tx, exp_line(500));
      rst_n = 1'b0;
      #1;
      check("rst_async_line", tx, 1);
      check("rst_async_ready", ready, 1);
      check("rst_async_active", active, 0);
      check("rst_async_done", done, 0);
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (done !== 1'b0) dcnt++;
      end
      rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (done !== 1'b0 || active !== 1'b0) dcnt++;
      end
      check("rst_no_done", dcnt, 0);
      check("rst_no_partial", rx_q.size(), 0);
      start_msg(8'hC4, "c4");
      finish_msg("c4", -5);
      idle_after("c4");

      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         repeat ($urandom_range(0, 30)) @(negedge clk);
         start_msg(b, $sformatf("rnd%0d", i));
         finish_msg($sformatf("rnd%0d", i), -5);
         idle_after($sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
